// File: rtl/alu_issuer.sv
// Command-driven initiator for the 16-bit combinational ALU: owns a small register file and serialises one command at a time.
// Optional build macro ALU_ISSUER_OVF_TRAP_EN suppresses writeback of overflowing ALU results.
`timescale 1ns/1ps
module alu_issuer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned REG_AW      = 2,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [3:0]            cmd_func,
  input  logic [REG_AW-1:0]     cmd_rd,
  input  logic [REG_AW-1:0]     cmd_rs1,
  input  logic [REG_AW-1:0]     cmd_rs2,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_ovf,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_func,
  input  logic [DATA_WIDTH-1:0] alu_c,
  input  logic                  alu_ovf,
  output logic                  ovf_sticky
);

  localparam int unsigned NREG  = 1 << REG_AW;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_ALU   = 2'd0;
  localparam logic [1:0] OP_LOADI = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_CLRST = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0]       rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   regs_q [NREG];
  logic [DATA_WIDTH-1:0]   regs_d [NREG];
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]              alu_func_q, alu_func_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_ovf_q, rsp_ovf_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    sticky_q, sticky_d;
  logic                    accept;
  logic                    exec_last;

  assign cmd_ready  = reset_n && (state_q == S_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign exec_last  = (cnt_q <= CNT_W'(1));

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_func   = alu_func_q;
  assign ovf_sticky = sticky_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_valid_q <= rsp_valid_d;
      sticky_q    <= sticky_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (cmd_op == OP_ALU) ? S_EXEC : S_RESP;
      S_EXEC: if (exec_last) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    regs_d      = regs_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    sticky_d    = sticky_q;
    rsp_valid_d = (state_d == S_RESP);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_ALU: begin
              alu_a_d    = regs_q[cmd_rs1];
              alu_b_d    = regs_q[cmd_rs2];
              alu_func_d = cmd_func;
              rd_d       = cmd_rd;
              cnt_d      = CNT_W'(ALU_LATENCY);
            end
            OP_LOADI: begin
              regs_d[cmd_rd] = cmd_imm;
              rsp_data_d     = cmd_imm;
              rsp_ovf_d      = 1'b0;
            end
            OP_READ: begin
              rsp_data_d = regs_q[cmd_rs1];
              rsp_ovf_d  = 1'b0;
            end
            OP_CLRST: begin
              sticky_d   = 1'b0;
              rsp_data_d = '0;
              rsp_ovf_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (exec_last) begin
          rsp_ovf_d = alu_ovf;
          sticky_d  = sticky_q | alu_ovf;
`ifdef ALU_ISSUER_OVF_TRAP_EN
          // Trapped overflow leaves the destination untouched and reports its old value
          if (alu_ovf) begin
            rsp_data_d = regs_q[rd_q];
          end else begin
            regs_d[rd_q] = alu_c;
            rsp_data_d   = alu_c;
          end
`else
          regs_d[rd_q] = alu_c;
          rsp_data_d   = alu_c;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_issuer.sv
// Scoreboard bench for alu_issuer: a behavioural register-file model predicts each response,
// a monitor compares every response handshake and checks hold stability under backpressure.
`timescale 1ns/1ps
module tb_alu_issuer;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 2;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [3:0]    cmd_func = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_ovf;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic [3:0]    alu_func;
  logic          alu_ovf;
  logic          ovf_sticky;

  always #5 clk = ~clk;

  alu_issuer #(.DATA_WIDTH(DW), .REG_AW(AW), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_func(cmd_func),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_c(alu_c), .alu_ovf(alu_ovf),
    .ovf_sticky(ovf_sticky)
  );

  // ALU arithmetic on signed integers: ADD=0, SUB=1, NOT=3, ARS=13, ZERO=15
  function automatic logic [DW:0] alu_ref(input logic [3:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb, r;
    logic [DW-1:0] c;
    logic ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = '0;
    ov = 1'b0;
    case (f)
      4'b0000: begin r = sa + sb; c = DW'(r); ov = (r > 32767) || (r < -32768); end
      4'b0001: begin r = sa - sb; c = DW'(r); ov = (r > 32767) || (r < -32768); end
      4'b0011: c = ~a;
      4'b1101: begin r = sa >>> 1; c = DW'(r); end
      default: c = '0;
    endcase
    return {ov, c};
  endfunction

  always_comb {alu_ovf, alu_c} = alu_ref(alu_func, alu_a, alu_b);

  typedef struct {
    logic [DW-1:0] data;
    logic          ovf;
    logic          sticky;
    logic          is_alu;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    f;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] mreg [4];
  logic          msticky;
  bit            hold_ready = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    msticky = 1'b0;
  endtask

  // Response-ready driver: random unless a test pins it low
  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: stability while stalled, scoreboard compare on each handshake
  initial begin
    bit            held = 1'b0;
    logic [DW-1:0] hd;
    logic          ho;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_data", 32'(rsp_data), 32'(hd));
        chk("hold_ovf", 32'(rsp_ovf), 32'(ho));
      end
      if (rsp_valid && rsp_ready) begin
        held = 1'b0;
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
          chk("ovf_sticky", 32'(ovf_sticky), 32'(e.sticky));
          if (e.is_alu) begin
            chk("alu_a", 32'(alu_a), 32'(e.a));
            chk("alu_b", 32'(alu_b), 32'(e.b));
            chk("alu_func", 32'(alu_func), 32'(e.f));
          end
        end
      end else if (rsp_valid) begin
        held = 1'b1;
        hd   = rsp_data;
        ho   = rsp_ovf;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Issue one command, update the model, push the prediction and check response latency
  task automatic issue(input logic [1:0] op, input logic [3:0] f, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] imm, input bit kill);
    int            waited = 0;
    int            lat = 0;
    exp_t          e;
    logic [DW:0]   r;
    while (!cmd_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_op = op; cmd_func = f; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (kill) return;
    e = '{data: '0, ovf: 1'b0, sticky: 1'b0, is_alu: 1'b0, a: '0, b: '0, f: '0};
    case (op)
      2'd0: begin
        e.is_alu = 1'b1;
        e.a = mreg[rs1];
        e.b = mreg[rs2];
        e.f = f;
        r = alu_ref(f, e.a, e.b);
        e.ovf = r[DW];
`ifdef ALU_ISSUER_OVF_TRAP_EN
        if (r[DW]) e.data = mreg[rd];
        else begin mreg[rd] = r[DW-1:0]; e.data = r[DW-1:0]; end
`else
        mreg[rd] = r[DW-1:0];
        e.data = r[DW-1:0];
`endif
        msticky = msticky | r[DW];
      end
      2'd1: begin mreg[rd] = imm; e.data = imm; end
      2'd2: e.data = mreg[rs1];
      default: begin msticky = 1'b0; e.data = '0; end
    endcase
    e.sticky = msticky;
    sb_q.push_back(e);
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_latency", 32'(lat), (op == 2'd0) ? 32'(LAT) : 32'd0);
  endtask

  initial begin
    logic [3:0] funcs [5];
    int         t;
    funcs[0] = 4'b0000; funcs[1] = 4'b0001; funcs[2] = 4'b0011; funcs[3] = 4'b1101; funcs[4] = 4'b1111;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_func", 32'(alu_func), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    issue(2'd1, 4'h0, 2'd0, 2'd0, 2'd0, 16'h1234, 1'b0);
    issue(2'd2, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0);

    // Signed ADD overflow into R2
    issue(2'd1, 4'h0, 2'd0, 2'd0, 2'd0, 16'h7FFF, 1'b0);
    issue(2'd1, 4'h0, 2'd1, 2'd0, 2'd0, 16'h0001, 1'b0);
    issue(2'd0, 4'b0000, 2'd2, 2'd0, 2'd1, 16'h0000, 1'b0);
    chk("add_ovf_sticky", 32'(ovf_sticky), 32'd1);
    issue(2'd2, 4'h0, 2'd0, 2'd2, 2'd0, 16'h0000, 1'b0);

    // SUB in place, then ARS in place
    issue(2'd1, 4'h0, 2'd0, 2'd0, 2'd0, 16'h8000, 1'b0);
    issue(2'd0, 4'b0001, 2'd0, 2'd0, 2'd1, 16'h0000, 1'b0);
    issue(2'd1, 4'h0, 2'd0, 2'd0, 2'd0, 16'h8000, 1'b0);
    issue(2'd0, 4'b1101, 2'd0, 2'd0, 2'd1, 16'h0000, 1'b0);
    issue(2'd2, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0);

    // Backpressure with an ignored command pulse
    hold_ready = 1'b1;
    issue(2'd0, 4'b0000, 2'd3, 2'd0, 2'd0, 16'h0000, 1'b0);
    cmd_op = 2'd1; cmd_rd = 2'd1; cmd_imm = 16'hDEAD; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    hold_ready = 1'b0;
    issue(2'd2, 4'h0, 2'd0, 2'd1, 2'd0, 16'h0000, 1'b0);

    // NOT with multi-cycle latency
    issue(2'd1, 4'h0, 2'd1, 2'd0, 2'd0, 16'h00FF, 1'b0);
    issue(2'd0, 4'b0011, 2'd2, 2'd1, 2'd0, 16'h0000, 1'b0);

    // CLRSTICKY after an overflow
    issue(2'd1, 4'h0, 2'd0, 2'd0, 2'd0, 16'h7FFF, 1'b0);
    issue(2'd0, 4'b0000, 2'd3, 2'd0, 2'd0, 16'h0000, 1'b0);
    issue(2'd3, 4'h0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b0);
    chk("clr_sticky_now", 32'(ovf_sticky), 32'd0);

    // Reset during EXEC aborts the command
    issue(2'd1, 4'h0, 2'd3, 2'd0, 2'd0, 16'h1111, 1'b0);
    issue(2'd1, 4'h0, 2'd1, 2'd0, 2'd0, 16'h7FFF, 1'b0);
    issue(2'd0, 4'b0000, 2'd3, 2'd1, 2'd1, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    chk("midrst_sticky", 32'(ovf_sticky), 32'd0);
    reset_n = 1'b1;
    model_reset();
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    issue(2'd2, 4'h0, 2'd0, 2'd3, 2'd0, 16'h0000, 1'b0);

    // Randomised command mix
    for (int n = 0; n < 80; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      issue((sel < 5) ? 2'd0 : (sel < 8) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3,
            funcs[$urandom_range(0, 4)], AW'($urandom), AW'($urandom), AW'($urandom),
            DW'($urandom), 1'b0);
    end

    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
